// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath blocks.
//   FIR_X_W    : FIR input sample width
//   FIR_Y_W    : FIR output sample width (feeds fir_output_decimator)
//   sat_signed : clip a signed value to the range of a signed 'width'-bit word
package fir_pkg;

   localparam int FIR_X_W = 8;
   localparam int FIR_Y_W = 16;

   function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                     input int                 width);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (width - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (width - 1));
      if (value > hi) return hi;
      if (value < lo) return lo;
      return value;
   endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, so full means exactly DEPTH entries.
// A push while full is accepted only when a pop happens in the same cycle.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push/wdata : write request and data
//   pop        : read request (ignored while empty)
//   rdata      : head entry (meaningless while empty)
//   full/empty : occupancy status
module fir_sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   // Storage needs no reset: it is only observed through non-empty pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/fir_output_decimator.sv
// Keeps one of every DECIM FIR output samples, rescales it by an arithmetic
// right shift of SHIFT bits, saturates to OUT_W bits and buffers the result
// in a FIFO drained over a valid/ready handshake. Samples arriving while the
// FIFO is full (and not being popped) are dropped and flagged.
//   clk, reset : clock, asynchronous active-high reset
//   y_in       : signed FIR sample, qualified by y_valid
//   d_out      : signed decimated sample at FIFO head (0 while empty)
//   d_valid    : FIFO not empty;  d_ready : consumer accepts d_out
//   sat_flag   : pulse, the sample written this cycle was clipped
//   overflow   : sticky, a decimated sample was dropped
// Build option: define FIR_DEC_ROUND_EN to round half up before the shift;
// otherwise the shift truncates toward -inf.
module fir_output_decimator
   import fir_pkg::*;
#(
   parameter int IN_W       = FIR_Y_W,
   parameter int OUT_W      = 8,
   parameter int SHIFT      = 4,
   parameter int DECIM      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IN_W-1:0]  y_in,
   input  logic             y_valid,
   output logic [OUT_W-1:0] d_out,
   output logic             d_valid,
   input  logic             d_ready,
   output logic             sat_flag,
   output logic             overflow
);

   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

`ifdef FIR_DEC_ROUND_EN
   localparam logic [IN_W:0] RND = (IN_W+1)'(1) << (SHIFT - 1);
`else
   localparam logic [IN_W:0] RND = '0;
`endif

   logic [PW-1:0]        phase_q, phase_d;
   logic                 accept;
   logic signed [IN_W:0] ext, shifted;
   logic signed [31:0]   wide, clipped;
   logic                 s1_valid_q, s1_sat_q;
   logic [OUT_W-1:0]     s1_data_q;
   logic                 sat_flag_q, overflow_q;
   logic [OUT_W:0]       fifo_rdata;
   logic                 fifo_full, fifo_empty;
   logic                 pop_fire, wr_ok;
   logic                 unused_sat;

   // Phase 0 is the keep slot, so the first valid sample after reset is kept.
   assign accept = y_valid && (phase_q == '0);

   always_comb begin
      phase_d = phase_q;
      if (y_valid) phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
   end

   // One extra bit of headroom keeps the rounding addend from wrapping.
   always_comb begin
      ext     = $signed({y_in[IN_W-1], y_in} + RND);
      shifted = ext >>> SHIFT;
      wide    = 32'(shifted);
      clipped = sat_signed(wide, OUT_W);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q    <= '0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_sat_q   <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         s1_valid_q <= accept;
         if (accept) begin
            s1_data_q <= clipped[OUT_W-1:0];
            s1_sat_q  <= (clipped != wide);
         end
      end
   end

   // A full FIFO still takes the write when the head leaves in the same cycle.
   assign pop_fire = d_ready && !fifo_empty;
   assign wr_ok    = s1_valid_q && (!fifo_full || pop_fire);

   fir_sync_fifo #(
      .WIDTH (OUT_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (s1_valid_q),
      .wdata ({s1_sat_q, s1_data_q}),
      .pop   (d_ready),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sat_flag_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         sat_flag_q <= wr_ok && s1_sat_q;
         overflow_q <= overflow_q || (s1_valid_q && !wr_ok);
      end
   end

   // The stored sat bit is carried with the sample but not exported.
   assign unused_sat = fifo_rdata[OUT_W];

   assign d_valid  = !fifo_empty;
   assign d_out    = fifo_empty ? '0 : fifo_rdata[OUT_W-1:0];
   assign sat_flag = sat_flag_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_fir_output_decimator.sv
// Randomized and directed stimulus against a sample-level reference model.
// The model keeps every DECIM-th valid sample, computes the expected output
// with floor division and clipping, and tracks buffered results in a queue
// that the negedge monitor compares against the DUT.
module tb_fir_output_decimator;

   localparam int IN_W  = 16;
   localparam int OUT_W = 8;
   localparam int SHIFT = 4;
   localparam int DECIM = 4;
   localparam int DEPTH = 4;
`ifdef FIR_DEC_ROUND_EN
   localparam int RND = 1 << (SHIFT - 1);
`else
   localparam int RND = 0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [IN_W-1:0]  y_in = '0;
   logic             y_valid = 1'b0;
   logic [OUT_W-1:0] d_out;
   logic             d_valid;
   logic             d_ready = 1'b0;
   logic             sat_flag;
   logic             overflow;

   int n_chk = 0;
   int n_pass = 0;

   fir_output_decimator #(
      .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(DECIM), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .y_in(y_in), .y_valid(y_valid),
      .d_out(d_out), .d_valid(d_valid), .d_ready(d_ready),
      .sat_flag(sat_flag), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Expected output for one kept sample: floor((y + RND) / 2^SHIFT), clipped.
   function automatic int scaled(input int y);
      int v, d;
      d = 1 << SHIFT;
      v = y + RND;
      return (v >= 0) ? v / d : -((-v + d - 1) / d);
   endfunction

   function automatic int clip(input int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   // ---------------- reference model ----------------
   int sb[$];
   int vcnt;
   bit pend_v, pend_sat, exp_sat, exp_ovf;
   int pend_val;
   bit m_pop, m_full;
   int m_raw;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sb.delete();
         vcnt = 0; pend_v = 0; pend_sat = 0; pend_val = 0;
         exp_sat = 0; exp_ovf = 0;
      end else begin
         m_full  = (sb.size() == DEPTH);
         m_pop   = d_ready && (sb.size() != 0);
         exp_sat = 0;
         if (m_pop) void'(sb.pop_front());
         if (pend_v) begin
            if (!m_full || m_pop) begin
               sb.push_back(pend_val);
               exp_sat = pend_sat;
            end else exp_ovf = 1;
         end
         pend_v = 0;
         if (y_valid) begin
            if (vcnt % DECIM == 0) begin
               m_raw    = scaled(int'($signed(y_in)));
               pend_val = clip(m_raw);
               pend_sat = (pend_val != m_raw);
               pend_v   = 1;
            end
            vcnt++;
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!reset) begin
         check("d_valid", int'(d_valid), int'(sb.size() != 0));
         if (d_valid && sb.size() != 0) check("d_out", int'($signed(d_out)), sb[0]);
         check("sat_flag", int'(sat_flag), int'(exp_sat));
         check("overflow", int'(overflow), int'(exp_ovf));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int y, input bit v, input bit rdy);
      @(negedge clk); #1;
      y_in = IN_W'(y); y_valid = v; d_ready = rdy;
   endtask

   // One DECIM-long group whose first valid sample lands on phase 0.
   task automatic kept(input int y, input bit rdy);
      cyc(y, 1'b1, rdy);
      repeat (DECIM - 1) cyc(int'($urandom), 1'b1, rdy);
   endtask

   int dir[] = '{80, 4000, -4000, 24, -24, 2032, 2040, -2048, -2056, 0, -1, 32767, -32768};

   initial begin
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst d_valid", int'(d_valid), 0);
      check("rst d_out", int'(d_out), 0);
      check("rst sat_flag", int'(sat_flag), 0);
      check("rst overflow", int'(overflow), 0);
      #1 reset = 1'b0;

      foreach (dir[i]) kept(dir[i], 1'b1);

      for (int k = 0; k < 16; k++) cyc(16 * k, 1'b1, 1'b1);
      repeat (4) cyc(0, 1'b0, 1'b1);

      // Full FIFO: the fifth sample is written in the same cycle as a pop.
      for (int i = 1; i <= 4; i++) kept(i * 32, 1'b0);
      cyc(5 * 32, 1'b1, 1'b0);
      cyc(1, 1'b1, 1'b1);
      cyc(2, 1'b1, 1'b1);
      cyc(3, 1'b1, 1'b1);
      repeat (8) cyc(0, 1'b0, 1'b1);

      // Backpressure: six kept samples, only the first four fit.
      for (int i = 1; i <= 6; i++) kept(i * 160, 1'b0);
      repeat (3) cyc(0, 1'b0, 1'b0);
      check("ovf after fill", int'(overflow), 1);
      repeat (8) cyc(0, 1'b0, 1'b1);
      check("ovf sticky", int'(overflow), 1);

      for (int i = 0; i < 600; i++)
         cyc(int'($urandom), $urandom_range(0, 9) < 8,
             (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      repeat (8) cyc(0, 1'b0, 1'b1);

      // Reset with three samples buffered.
      for (int i = 1; i <= 3; i++) kept(i * 48, 1'b0);
      repeat (2) cyc(0, 1'b0, 1'b0);
      @(negedge clk); #3;
      reset = 1'b1;
      #1;
      check("midrst d_valid", int'(d_valid), 0);
      check("midrst d_out", int'(d_out), 0);
      check("midrst overflow", int'(overflow), 0);
      @(negedge clk); #2 reset = 1'b0;

      kept(-48, 1'b1);
      kept(1000, 1'b1);

      for (int i = 0; i < 50 && sb.size() != 0; i++) cyc(0, 1'b0, 1'b1);
      repeat (3) cyc(0, 1'b0, 1'b1);
      check("drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fir_output_decimator.md
# fir_output_decimator

Downstream stage of `fir_filter`. It takes the 16-bit signed FIR output stream and keeps one sample in every `DECIM`. Each kept sample is rescaled by an arithmetic right shift, optionally rounded, and saturated to 8 bits. Results are buffered in a small FIFO and presented to the consumer over a valid/ready handshake.

## Interface
- `IN_W`, 16: input sample width (matches `fir_filter` `y_out`)
- `OUT_W`, 8: output sample width
- `SHIFT`, 4: LSBs discarded by the rescale; must be ≥1
- `DECIM`, 4: decimation ratio; must be ≥1 (1 = pass every sample)
- `FIFO_DEPTH`, 4: output buffer entries; power of two, ≥2
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `y_in` in `IN_W`: signed sample from `fir_filter.y_out`
- `y_valid` in 1: `y_in` is a new sample this cycle (tied high when the FIR runs every cycle)
- `d_out` out `OUT_W`: signed decimated sample at FIFO head
- `d_valid` out 1: `d_out` holds valid data
- `d_ready` in 1: consumer accepts `d_out` this cycle
- `sat_flag` out 1: one-cycle pulse, the sample written to FIFO this cycle was clipped
- `overflow` out 1: sticky; a decimated sample was dropped because the FIFO was full

## Operation
- Phase counter `phase`, range 0..`DECIM`-1:
  - Advances only on `y_valid`, wrapping from `DECIM`-1 to 0.
  - A sample is accepted when `y_valid && phase==0`, so the first valid sample after reset is kept.
- Stage 1 register (`s1_valid`, `s1_data`) captures the rescaled and saturated value at the accept edge:
  - Rescale: extend to `IN_W`+1 bits, add the rounding constant (see Configuration), then arithmetic shift right by `SHIFT`.
  - Saturate: values above 2^(`OUT_W`-1)-1 clip to 127; values below -2^(`OUT_W`-1) clip to -128. A per-sample sat bit travels with the data.
- FIFO write happens when `s1_valid` is set:
  - Not full: write the sample. `sat_flag` pulses in the same cycle if that sample was clipped.
  - Full with no pop this cycle: drop the sample and set `overflow`. `sat_flag` does not pulse. FIFO contents are unchanged.
  - Full with a simultaneous pop (`d_valid && d_ready`): pop and push both occur and nothing is dropped.
- Output side:
  - `d_valid` = FIFO not empty; `d_out` = head entry.
  - A pop occurs on `d_valid && d_ready`. `d_ready` while empty has no effect.
- `overflow` stays high until `reset`.
- Reset values: `phase`=0, `s1_valid`=0, FIFO empty, `d_valid`=0, `d_out`=0, `sat_flag`=0, `overflow`=0.
- Reset asserted mid-operation discards every buffered and in-flight sample immediately (asynchronously).

## Timing
- Latency, empty FIFO: a sample accepted at edge N is captured in stage 1 at N, written at N+1, and `d_valid`/`d_out` are valid after N+1. Total: 2 edges from accept to output.
- Throughput: with `DECIM`=1, up to 1 sample per cycle in and out; sustained with `d_ready` held high.
- Stage 1 never stalls. Backpressure is absorbed only by the FIFO, and excess samples are dropped rather than backpressuring the FIR, which has no ready.
- `sat_flag` is registered and aligned with the FIFO write edge.
- Full/empty status uses pointers with an extra wrap bit, so the full state is exactly `FIFO_DEPTH` entries.

## Configuration
- `FIR_DEC_ROUND_EN` defined: add 2^(`SHIFT`-1) before the shift (round half up toward +inf).
- Not defined: no addend, plain truncating arithmetic shift (toward -inf).
- The macro has no other effect on timing or interface.

## Structure
- Shared package `fir_pkg`:
  - Constants `FIR_X_W`=8 and `FIR_Y_W`=16.
  - Function `sat_signed(value, width)`, reused by `fir_filter` accumulators.
- One sub-module, `fir_sync_fifo`:
  - Parameters width and depth; ports push/pop/full/empty; async active-high reset.
  - Instantiated once with width `OUT_W`+1 (data plus sat bit).

## Test plan
- **Basic scaling**: `DECIM`=1, `d_ready`=1, `y_in`=80 → `d_out`=5 two edges later, `sat_flag`=0.
- **Saturation**: `y_in`=4000 → `d_out`=127 with a `sat_flag` pulse; `y_in`=-4000 → `d_out`=-128 with a `sat_flag` pulse.
- **Rounding**:
  - `y_in`=24 → 2 with `FIR_DEC_ROUND_EN`, 1 without.
  - `y_in`=-24 → -1 with the macro, -2 without.
- **Decimation**: `DECIM`=4, continuous `y_valid`, `y_in`=16·k for k=0..15 → outputs 0, 4, 8, 12 in order, with no extra outputs.
- **Backpressure and overflow**:
  - `d_ready`=0 while 6 samples (10, 20, …, 60 ×16) are accepted → FIFO holds 10, 20, 30, 40 and `overflow`=1.
  - Then `d_ready`=1 → exactly those 4 drain in order, and `overflow` stays 1.
  - Full FIFO with a pop in the same cycle as a write → no drop.
- **Reset mid-operation**: assert `reset` asynchronously with 3 entries buffered → `d_valid`=0, `d_out`=0, `overflow`=0 immediately. After release, the first valid sample is accepted (`phase`=0).
